// File: rtl/pl_framer_if.sv
// Symbol streams around the physical-layer framer: header and payload sources in,
// framed symbol stream out. The framer side uses the slave modport.
interface pl_framer_if;
    logic        hdr_valid;
    logic [15:0] hdr_real;
    logic [15:0] hdr_imag;
    logic        hdr_ready;

    logic        pld_valid;
    logic [15:0] pld_real;
    logic [15:0] pld_imag;
    logic        pld_ready;

    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_real;
    logic [15:0] out_imag;
    logic        out_sof;
    logic        out_eof;
    logic        out_pilot;

    modport slave (
        input  hdr_valid, hdr_real, hdr_imag,
        output hdr_ready,
        input  pld_valid, pld_real, pld_imag,
        output pld_ready,
        output out_valid, out_real, out_imag, out_sof, out_eof, out_pilot,
        input  out_ready
    );

    modport master (
        output hdr_valid, hdr_real, hdr_imag,
        input  hdr_ready,
        output pld_valid, pld_real, pld_imag,
        input  pld_ready,
        input  out_valid, out_real, out_imag, out_sof, out_eof, out_pilot,
        output out_ready
    );
endinterface

// File: rtl/pl_framer.sv
// Builds frames of 90 header symbols followed by PAYLOAD_SLOTS 90-symbol payload slots,
// with an optional 36-symbol pilot block after every 16th slot, through a one-deep output register.
module pl_framer #(
    parameter int PAYLOAD_SLOTS = 360,
    parameter bit PILOTS_EN     = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    pl_framer_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, HDR, PLD, PILOT} state_t;

    localparam logic [9:0]  LAST_SLOT = 10'(PAYLOAD_SLOTS - 1);
    localparam logic [15:0] PILOT_VAL = 16'h00B5;

    state_t      state_q, state_d;
    logic [6:0]  hdr_cnt_q, hdr_cnt_d;
    logic [6:0]  sym_cnt_q, sym_cnt_d;
    logic [9:0]  slot_cnt_q, slot_cnt_d;
    logic [5:0]  pil_cnt_q, pil_cnt_d;

    logic        out_valid_q, out_valid_d;
    logic [15:0] out_real_q, out_real_d;
    logic [15:0] out_imag_q, out_imag_d;
    logic        out_sof_q, out_sof_d;
    logic        out_eof_q, out_eof_d;
    logic        out_pilot_q, out_pilot_d;

    logic        stage_free;
    logic        hdr_acc;
    logic        pld_acc;

    // Readiness is held low during reset so nothing is consumed on a reset edge.
    assign stage_free    = !out_valid_q || bus.out_ready;
    assign bus.hdr_ready = !rst && stage_free && (state_q == IDLE || state_q == HDR);
    assign bus.pld_ready = !rst && stage_free && (state_q == PLD);
    assign hdr_acc       = bus.hdr_valid && bus.hdr_ready;
    assign pld_acc       = bus.pld_valid && bus.pld_ready;

    assign bus.out_valid = out_valid_q;
    assign bus.out_real  = out_real_q;
    assign bus.out_imag  = out_imag_q;
    assign bus.out_sof   = out_sof_q;
    assign bus.out_eof   = out_eof_q;
    assign bus.out_pilot = out_pilot_q;

    always_comb begin
        state_d     = state_q;
        hdr_cnt_d   = hdr_cnt_q;
        sym_cnt_d   = sym_cnt_q;
        slot_cnt_d  = slot_cnt_q;
        pil_cnt_d   = pil_cnt_q;
        out_valid_d = out_valid_q;
        out_real_d  = out_real_q;
        out_imag_d  = out_imag_q;
        out_sof_d   = out_sof_q;
        out_eof_d   = out_eof_q;
        out_pilot_d = out_pilot_q;

        // A stalled output register freezes the whole block.
        if (stage_free) begin
            out_valid_d = 1'b0;
            out_sof_d   = 1'b0;
            out_eof_d   = 1'b0;
            out_pilot_d = 1'b0;

            unique case (state_q)
                IDLE: begin
                    if (hdr_acc) begin
                        out_valid_d = 1'b1;
                        out_real_d  = bus.hdr_real;
                        out_imag_d  = bus.hdr_imag;
                        out_sof_d   = 1'b1;
                        hdr_cnt_d   = 7'd1;
                        state_d     = HDR;
                    end
                end
                HDR: begin
                    if (hdr_acc) begin
                        out_valid_d = 1'b1;
                        out_real_d  = bus.hdr_real;
                        out_imag_d  = bus.hdr_imag;
                        if (hdr_cnt_q == 7'd89) begin
                            hdr_cnt_d  = 7'd0;
                            sym_cnt_d  = 7'd0;
                            slot_cnt_d = 10'd0;
                            state_d    = PLD;
                        end else begin
                            hdr_cnt_d = hdr_cnt_q + 7'd1;
                        end
                    end
                end
                PLD: begin
                    if (pld_acc) begin
                        out_valid_d = 1'b1;
                        out_real_d  = bus.pld_real;
                        out_imag_d  = bus.pld_imag;
                        if (sym_cnt_q == 7'd89) begin
                            sym_cnt_d = 7'd0;
                            if (slot_cnt_q == LAST_SLOT) begin
                                out_eof_d  = 1'b1;
                                slot_cnt_d = 10'd0;
                                state_d    = IDLE;
                            end else begin
                                slot_cnt_d = slot_cnt_q + 10'd1;
                                // Low nibble of 15 means (slot_cnt+1) is a multiple of 16.
                                if (PILOTS_EN && slot_cnt_q[3:0] == 4'hF) begin
                                    pil_cnt_d = 6'd0;
                                    state_d   = PILOT;
                                end
                            end
                        end else begin
                            sym_cnt_d = sym_cnt_q + 7'd1;
                        end
                    end
                end
                PILOT: begin
                    out_valid_d = 1'b1;
                    out_real_d  = PILOT_VAL;
                    out_imag_d  = PILOT_VAL;
                    out_pilot_d = 1'b1;
                    if (pil_cnt_q == 6'd35) begin
                        pil_cnt_d = 6'd0;
                        state_d   = PLD;
                    end else begin
                        pil_cnt_d = pil_cnt_q + 6'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            hdr_cnt_q   <= 7'd0;
            sym_cnt_q   <= 7'd0;
            slot_cnt_q  <= 10'd0;
            pil_cnt_q   <= 6'd0;
            out_valid_q <= 1'b0;
            out_real_q  <= 16'd0;
            out_imag_q  <= 16'd0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            out_pilot_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hdr_cnt_q   <= hdr_cnt_d;
            sym_cnt_q   <= sym_cnt_d;
            slot_cnt_q  <= slot_cnt_d;
            pil_cnt_q   <= pil_cnt_d;
            out_valid_q <= out_valid_d;
            out_real_q  <= out_real_d;
            out_imag_q  <= out_imag_d;
            out_sof_q   <= out_sof_d;
            out_eof_q   <= out_eof_d;
            out_pilot_q <= out_pilot_d;
        end
    end
endmodule

// File: tb/tb_pl_framer.sv
// Directed bench for pl_framer: reset behaviour, reset mid-pilot, then a full default
// frame with input gaps and an output stall, plus a pilot-free instance run alongside.
module tb_pl_framer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pl_framer_if bus ();
    pl_framer_if np_if ();

    pl_framer u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    pl_framer #(.PAYLOAD_SLOTS(360), .PILOTS_EN(1'b0)) u_np (
        .clk (clk),
        .rst (rst),
        .bus (np_if.slave)
    );

    // Pilot-free instance: always-on sources, always-ready sink.
    assign np_if.hdr_valid = 1'b1;
    assign np_if.hdr_real  = 16'h0101;
    assign np_if.hdr_imag  = 16'h0202;
    assign np_if.pld_valid = 1'b1;
    assign np_if.pld_real  = 16'h0303;
    assign np_if.pld_imag  = 16'h0404;
    assign np_if.out_ready = 1'b1;

    int np_idx, np_eof_idx, np_sof_idx, np_pilots;
    always @(posedge clk) begin
        if (rst) begin
            np_idx     <= 0;
            np_eof_idx <= -1;
            np_sof_idx <= -1;
            np_pilots  <= 0;
        end else if (np_if.out_valid && np_if.out_ready) begin
            np_idx <= np_idx + 1;
            if (np_if.out_pilot) np_pilots <= np_pilots + 1;
            if (np_if.out_sof && np_sof_idx < 0) np_sof_idx <= np_idx;
            if (np_if.out_eof && np_eof_idx < 0) np_eof_idx <= np_idx;
        end
    end

    int          n_cmp = 0;
    int          n_bad = 0;
    int          hp, pp, fidx, cyc, eof_idx, pilot_cnt;
    bit          tog_en;
    logic        ready_drv;
    logic        prev_stall;
    logic [35:0] prev_obs;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [35:0] obs_now();
        return {bus.out_valid, bus.out_real, bus.out_imag, bus.out_sof, bus.out_eof, bus.out_pilot};
    endfunction

    // Expected symbol at frame index i for the default frame (360 slots, pilots on).
    function automatic logic [35:0] exp_sym(input int i);
        int p, g, r, j;
        if (i < 90)
            return {1'b1, 16'h1000 + 16'(i), 16'hE000 ^ 16'(i), (i == 0), 1'b0, 1'b0};
        p = i - 90;
        g = p / 1476;
        r = p % 1476;
        if (r >= 1440)
            return {1'b1, 16'h00B5, 16'h00B5, 1'b0, 1'b0, 1'b1};
        j = g * 1440 + r;
        return {1'b1, 16'(j), 16'(j * 3 + 7), 1'b0, (j == 32399), 1'b0};
    endfunction

    task automatic run_cycle();
        logic h_acc, p_acc;
        bus.hdr_valid = 1'b1;
        bus.hdr_real  = 16'h1000 + 16'(hp);
        bus.hdr_imag  = 16'hE000 ^ 16'(hp);
        bus.pld_valid = !(tog_en && (cyc % 2 == 1));
        bus.pld_real  = 16'(pp);
        bus.pld_imag  = 16'(pp * 3 + 7);
        bus.out_ready = ready_drv;
        #2;
        if (prev_stall) chk("hold_stable", 64'(obs_now()), 64'(prev_obs));
        if (bus.out_valid && !bus.out_ready) chk("stall_pld_ready", 64'(bus.pld_ready), 64'd0);
        if (bus.out_valid && bus.out_ready) begin
            chk($sformatf("sym%0d", fidx), 64'(obs_now()), 64'(exp_sym(fidx)));
            if (bus.out_pilot) pilot_cnt++;
            if (bus.out_eof && eof_idx < 0) eof_idx = fidx;
            fidx++;
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_obs   = obs_now();
        h_acc = bus.hdr_valid && bus.hdr_ready;
        p_acc = bus.pld_valid && bus.pld_ready;
        @(posedge clk);
        #1;
        if (h_acc) hp = (hp == 89) ? 0 : hp + 1;
        if (p_acc) pp++;
        cyc++;
    endtask

    initial begin
        int  k;
        bit  stall_done;
        rst        = 1'b1;
        ready_drv  = 1'b1;
        prev_stall = 1'b0;
        prev_obs   = '0;
        tog_en     = 1'b0;
        hp = 0; pp = 0; fidx = 0; cyc = 0; eof_idx = -1; pilot_cnt = 0;

        // Reset with random inputs.
        for (int c = 0; c < 2; c++) begin
            bus.hdr_valid = 1'($urandom);
            bus.hdr_real  = 16'($urandom);
            bus.hdr_imag  = 16'($urandom);
            bus.pld_valid = 1'($urandom);
            bus.pld_real  = 16'($urandom);
            bus.pld_imag  = 16'($urandom);
            bus.out_ready = 1'($urandom);
            @(posedge clk);
            #1;
            chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
            chk("rst_out_real",  64'(bus.out_real),  64'd0);
            chk("rst_out_imag",  64'(bus.out_imag),  64'd0);
            chk("rst_out_sof",   64'(bus.out_sof),   64'd0);
            chk("rst_out_eof",   64'(bus.out_eof),   64'd0);
            chk("rst_out_pilot", 64'(bus.out_pilot), 64'd0);
            chk("rst_hdr_ready", 64'(bus.hdr_ready), 64'd0);
            chk("rst_pld_ready", 64'(bus.pld_ready), 64'd0);
        end
        rst = 1'b0;
        #1;
        chk("hdr_ready_after_rst", 64'(bus.hdr_ready), 64'd1);

        // Run into the first pilot block, then reset on pilot symbol 10.
        k = 0;
        while (fidx < 1540 && k < 3000) begin
            run_cycle();
            k++;
        end
        chk("reach_pilot10", 64'(fidx), 64'd1540);
        chk("pilot10_on_out", 64'({bus.out_valid, bus.out_pilot}), 64'd3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_out_pilot", 64'(bus.out_pilot), 64'd0);
        rst = 1'b0;
        #1;
        chk("midrst_hdr_ready", 64'(bus.hdr_ready), 64'd1);
        hp = 0; pp = 0; fidx = 0; eof_idx = -1; pilot_cnt = 0; prev_stall = 1'b0;

        // Fresh full frame: pld_valid toggling over indices 1000..1999, 5-cycle stall at 3000.
        k = 0;
        stall_done = 1'b0;
        while (eof_idx < 0 && k < 40000) begin
            tog_en = (fidx >= 1000 && fidx < 2000);
            if (fidx == 3000 && !stall_done) begin
                ready_drv = 1'b0;
                repeat (5) run_cycle();
                ready_drv  = 1'b1;
                stall_done = 1'b1;
                k += 5;
            end
            run_cycle();
            k++;
        end
        chk("frame_eof_idx",   64'(eof_idx),   64'd33281);
        chk("frame_len",       64'(fidx),      64'd33282);
        chk("frame_pilot_cnt", 64'(pilot_cnt), 64'd792);
        chk("stall_seen",      64'(stall_done), 64'd1);

        chk("np_sof_idx", 64'(np_sof_idx), 64'd0);
        chk("np_eof_idx", 64'(np_eof_idx), 64'd32489);
        chk("np_pilots",  64'(np_pilots),  64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pl_framer.md
PL_FRAMER -- requirements
Module: pl_framer

Interface
REQ-001 The block SHALL have the parameter PAYLOAD_SLOTS, default 360, giving the number of 90-symbol payload slots per frame (range 1..1023).
REQ-002 The block SHALL have the parameter PILOTS_EN, default 1: 1 inserts pilot blocks, 0 omits them.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset; its ports SHALL be as follows (clock and reset first):
  clk        in   1   single clock, rising edge
  rst        in   1   synchronous active-high reset
  hdr_valid  in   1   header symbol present
  hdr_real   in   16  header symbol I, two's complement Q8.8
  hdr_imag   in   16  header symbol Q, Q8.8
  hdr_ready  out  1   header symbol accepted this cycle when high with hdr_valid
  pld_valid  in   1   payload symbol present
  pld_real   in   16  payload I, Q8.8
  pld_imag   in   16  payload Q, Q8.8
  pld_ready  out  1   payload symbol accepted when high with pld_valid
  out_valid  out  1   output symbol present
  out_ready  in   1   downstream accepts output
  out_real   out  16  output I
  out_imag   out  16  output Q
  out_sof    out  1   first header symbol of frame
  out_eof    out  1   last payload symbol of frame
  out_pilot  out  1   symbol is a pilot

Function
REQ-004 The FSM SHALL have the states IDLE, HDR, PLD and PILOT.
REQ-005 The frame order SHALL be: 90 header symbols, then PAYLOAD_SLOTS slots of 90 payload symbols; with PILOTS_EN=1, a 36-symbol pilot block SHALL follow every 16th slot, except when that slot is the last one.
REQ-006 The frame length SHALL be 90 + 90*PAYLOAD_SLOTS + 36*floor((PAYLOAD_SLOTS-1)/16) symbols with pilots, or 90 + 90*PAYLOAD_SLOTS without them; the defaults give 33282 and 32490.
REQ-007 The output stage SHALL be a single register; define stage_free = !out_valid || out_ready.
REQ-008 Readiness SHALL be: hdr_ready = stage_free && state in {IDLE, HDR}; pld_ready = stage_free && state==PLD; neither SHALL be asserted in PILOT.
REQ-009 An accepted symbol SHALL appear on out_real/out_imag on the next cycle with out_valid=1, giving a latency of 1 cycle and no data modification.
REQ-010 While out_valid=1 and out_ready=0, all out_* SHALL hold stable and no input SHALL be accepted.
REQ-011 IDLE -> HDR SHALL occur on the first accepted header symbol; that symbol SHALL be output with out_sof=1.
REQ-012 HDR -> PLD SHALL occur after the 90th accepted header symbol (hdr_cnt 0..89).
REQ-013 PLD SHALL count sym_cnt 0..89 and slot_cnt 0..PAYLOAD_SLOTS-1, advancing only on accepted symbols.
REQ-014 At the end of a slot: when it is the last slot, the block SHALL go to IDLE and the symbol SHALL carry out_eof=1; otherwise, when PILOTS_EN=1 and (slot_cnt+1)%16==0, it SHALL go to PILOT; otherwise it SHALL stay in PLD.
REQ-015 In PILOT the block SHALL generate 36 symbols at 0x00B5/0x00B5 with out_pilot=1, one per stage_free cycle, and then return to PLD.
REQ-016 Input gaps (valid low) SHALL insert output bubbles (out_valid=0) and SHALL NOT advance any counter.
REQ-017 hdr_valid SHALL be ignored outside IDLE/HDR, and pld_valid SHALL be ignored outside PLD; no error SHALL be flagged.
REQ-018 out_sof, out_eof and out_pilot SHALL be valid only with out_valid=1 and SHALL be 0 otherwise.

Reset
REQ-019 On a clock edge with rst=1, the block SHALL set state=IDLE, clear all counters, and set out_valid=0, out_real=out_imag=0, out_sof=out_eof=out_pilot=0.
REQ-020 Reset SHALL take priority over every other event, including a mid-frame or mid-pilot reset; hdr_ready SHALL be 1 on the first cycle after rst deasserts.
REQ-021 The frame following a reset SHALL start with a header and slot_cnt=0; no partial frame SHALL resume.

Verification
REQ-022 rst=1 for 2 cycles with random inputs -> out_valid=0, all outputs 0, pld_ready=0, hdr_ready=0 during reset.
REQ-023 Defaults, out_ready=1, continuous inputs -> 33282 output symbols; out_sof on symbol 0; out_pilot on indices 1530..1565; 22 pilot blocks, each spaced 1476 symbols apart; no pilots after slot 359; out_eof on index 33281.
REQ-024 PILOTS_EN=0, PAYLOAD_SLOTS=360 -> 32490 symbols, out_pilot never set, out_eof on index 32489.
REQ-025 out_ready low for 5 cycles mid-payload -> out_* stable, pld_ready=0 throughout, and the output sequence equals the input sequence with no loss or duplication.
REQ-026 pld_valid toggling 1/0 -> the same symbol sequence with bubbles; pilot positions are unchanged in symbol-index terms.
REQ-027 rst pulsed at pilot symbol 10 -> out_valid=0 on the next cycle; the subsequent header yields out_sof and a fresh 33282-symbol frame.
